ncca_seq_mul8_ctrl: RTL and testbench
=====================================

Name: ncca_seq_mul8_ctrl

Overview:
- Sequential controller that time-shares one 4x4 nibble multiplier core to form an 8x8 product.
- Passes run in four quadrant steps: LL, LH, HL, HH.
- A 4-bit configuration word selects exact or approximate mode per quadrant.
- Sits between a valid/ready operand source and a valid/ready result sink. It is the area-reduced sequential counterpart of the parallel four-core 8x8 approximate multiplier.

Parameters:
- IN_W, 8, operand width; only 8 is supported (two 4-bit nibbles).
- OUT_W, 16, product/accumulator width; must equal 2*IN_W.
- DEFAULT_CFG, 4'b0111, reset value of cfg register. Bit order {HH,HL,LH,LL}; 1 = approximate, 0 = exact.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  8  multiplicand.
- in_b  input  8  multiplier.
- cfg_we  input  1  write strobe for the per-quadrant mode register.
- cfg_wdata  input  4  new mode word {HH,HL,LH,LL}.
- cfg_q  output  4  current mode register contents.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- out_prod  output  16  accumulated product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, out_prod=0, busy=0, cfg_q=DEFAULT_CFG, accumulator and operand/cfg snapshots=0.
- Reset asserted mid-transaction aborts it immediately; no output is produced for it.
- States: IDLE, Q_LL, Q_LH, Q_HL, Q_HH, DONE.
- in_ready = (state==IDLE).
- Accept occurs on in_valid && in_ready. On accept:
  - latch a, b and a snapshot of cfg_q;
  - clear the accumulator;
  - go to Q_LL.
- Quadrant steps, one per cycle, in the fixed order Q_LL -> Q_LH -> Q_HL -> Q_HH -> DONE:
  - LL = a[3:0]*b[3:0], shift 0
  - LH = a[3:0]*b[7:4], shift 4
  - HL = a[7:4]*b[3:0], shift 4
  - HH = a[7:4]*b[7:4], shift 8
  - Each step adds (pp << shift) to the accumulator, modulo 2^16.
- Core product pp (8-bit):
  - exact mode: the full nibble product;
  - approximate mode: the same product with pp[1:0] forced to 0.
- Latency and throughput:
  - accept in cycle 0; out_valid rises in cycle 5;
  - out_prod is registered and stable while out_valid=1;
  - one result per 6 cycles at full throughput (DONE->IDLE costs one cycle).
- DONE state:
  - out_valid=1 and held until out_ready;
  - out_valid && out_ready -> IDLE with out_valid=0;
  - out_prod keeps its last value until the next DONE.
- Config register:
  - a cfg_we write updates cfg_q on the next edge in any state;
  - an in-flight transaction uses its snapshot, so a write while busy affects only later transactions;
  - cfg_we and an accept in the same cycle: the transaction uses the old value.
- in_valid while busy: ignored, in_ready=0. The source holds its data per valid/ready rules.

Optional Feature:
- NCCA_ZERO_SKIP_EN defined:
  - a quadrant whose either operand nibble is zero is skipped, with no accumulate and no cycle spent;
  - the next state is the next non-skipped quadrant, or DONE;
  - if in_a==0 or in_b==0, accept goes directly to DONE with out_prod=0 (out_valid in cycle 1).
- Undefined: all four quadrant cycles always run; latency is fixed at 5.

Decomposition:
- Shared package ncca_mul_pkg holds:
  - state enum;
  - quadrant index constants;
  - the QUAD_SHIFT table {0,4,4,8};
  - cfg bit positions;
  - NIB_W=4.
- One sub-module, ncca_nib_mul4: combinational 4x4 core with a mode input, producing the 8-bit pp. It is replaceable by the LUT-mapped approximate cores without controller changes.
- The controller holds the FSM, the snapshots and the 16-bit accumulator.

Test Plan:
- cfg=4'b0000, a=0xFF, b=0xFF, out_ready=1 -> out_prod=0xFE01, out_valid rises exactly 5 cycles after accept, in_ready low cycles 1-5.
- cfg=4'b1111, a=0x37, b=0x25 -> out_prod=0x05A0; the same operands with cfg=4'b0000 -> 0x07F3.
- Backpressure: out_ready=0 for 7 cycles after DONE with a=0x12, b=0x34 (exact) -> out_valid and out_prod=0x03A8 held stable; in_ready stays 0; exactly one handshake when out_ready=1.
- cfg_we with cfg_wdata=4'b1111 in cycle 2 of an exact a=0x37, b=0x25 transaction -> result 0x07F3; cfg_q=0xF; the next identical transaction gives 0x05A0.
- Assert rst in cycle 3 of a transaction -> immediate IDLE, out_valid=0, cfg_q=DEFAULT_CFG; no stale out_valid after release.
- With NCCA_ZERO_SKIP_EN, exact cfg:
  - a=0x0F, b=0x0F -> 0x00E1 at cycle 2;
  - a=0x00, b=0x5A -> 0x0000 at cycle 1.
  - Without the macro both cases complete at cycle 5.

Source files
------------

// File: rtl/ncca_mul_pkg.sv
// Shared types and constants for the sequential 8x8 nibble multiplier controller.
package ncca_mul_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q_LL = 3'd1,
    Q_LH = 3'd2,
    Q_HL = 3'd3,
    Q_HH = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] QIDX_LL = 2'd0;
  localparam logic [1:0] QIDX_LH = 2'd1;
  localparam logic [1:0] QIDX_HL = 2'd2;
  localparam logic [1:0] QIDX_HH = 2'd3;

  localparam int CFG_LL = 0;
  localparam int CFG_LH = 1;
  localparam int CFG_HL = 2;
  localparam int CFG_HH = 3;

  // Left shift of each quadrant's partial product, indexed by quadrant.
  localparam logic [3:0][3:0] QUAD_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

  // First quadrant still to run in a remaining-work mask, or DONE when none is left.
  function automatic state_t pick_state(input logic [3:0] rem);
    state_t s;
    if (rem[QIDX_LL])      s = Q_LL;
    else if (rem[QIDX_LH]) s = Q_LH;
    else if (rem[QIDX_HL]) s = Q_HL;
    else if (rem[QIDX_HH]) s = Q_HH;
    else                   s = DONE;
    return s;
  endfunction

  function automatic logic [3:0] nz_mask(input logic [7:0] a, input logic [7:0] b);
    logic a_lo, a_hi, b_lo, b_hi;
    a_lo = |a[3:0];
    a_hi = |a[7:4];
    b_lo = |b[3:0];
    b_hi = |b[7:4];
    return {a_hi & b_hi, a_hi & b_lo, a_lo & b_hi, a_lo & b_lo};
  endfunction

endpackage

// File: rtl/ncca_nib_mul4.sv
// Combinational 4x4 nibble multiplier core; approximate mode zeroes the two product LSBs.
module ncca_nib_mul4
  import ncca_mul_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  input  logic               approx_i,
  output logic [2*NIB_W-1:0] pp_o
);

  logic [2*NIB_W-1:0] exact;

  assign exact = a_i * b_i;
  assign pp_o  = approx_i ? {exact[2*NIB_W-1:2], 2'b00} : exact;

endmodule

// File: rtl/ncca_seq_mul8_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 core stepped over LL, LH, HL, HH with per-quadrant mode.
// Define NCCA_ZERO_SKIP_EN to skip quadrants that have a zero operand nibble.
module ncca_seq_mul8_ctrl
  import ncca_mul_pkg::*;
#(
  parameter int         IN_W        = 8,
  parameter int         OUT_W       = 16,
  parameter logic [3:0] DEFAULT_CFG = 4'b0111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_wdata,
  output logic [3:0]       cfg_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_prod,
  output logic             busy
);

  state_t             state_q;
  logic [IN_W-1:0]    a_q, b_q;
  logic [3:0]         snap_q, cfg_reg_q;
  logic [OUT_W-1:0]   acc_q, acc_d, out_prod_q;
  logic               in_ready_q, out_valid_q, busy_q;

  logic [1:0]         cur_idx;
  logic               mode;
  logic [NIB_W-1:0]   a_nib, b_nib;
  logic [2*NIB_W-1:0] pp;
  logic [OUT_W-1:0]   term;
  logic [3:0]         in_mask, run_mask;
  state_t             accept_nxt, quad_nxt;

  always_comb begin
    cur_idx = QIDX_LL;
    mode    = snap_q[CFG_LL];
    case (state_q)
      Q_LH:    begin cur_idx = QIDX_LH; mode = snap_q[CFG_LH]; end
      Q_HL:    begin cur_idx = QIDX_HL; mode = snap_q[CFG_HL]; end
      Q_HH:    begin cur_idx = QIDX_HH; mode = snap_q[CFG_HH]; end
      default: ;
    endcase
  end

  // Index bit 1 picks the high nibble of a, bit 0 the high nibble of b.
  assign a_nib = cur_idx[1] ? a_q[2*NIB_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign b_nib = cur_idx[0] ? b_q[2*NIB_W-1:NIB_W] : b_q[NIB_W-1:0];

  ncca_nib_mul4 u_core (
    .a_i      (a_nib),
    .b_i      (b_nib),
    .approx_i (mode),
    .pp_o     (pp)
  );

  assign term  = {{(OUT_W-2*NIB_W){1'b0}}, pp} << QUAD_SHIFT[cur_idx];
  assign acc_d = acc_q + term;

`ifdef NCCA_ZERO_SKIP_EN
  assign in_mask  = nz_mask(in_a, in_b);
  assign run_mask = nz_mask(a_q, b_q);
`else
  assign in_mask  = 4'b1111;
  assign run_mask = 4'b1111;
`endif

  assign accept_nxt = pick_state(in_mask);
  assign quad_nxt   = pick_state(run_mask & (4'b1110 << cur_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      snap_q      <= '0;
      cfg_reg_q   <= DEFAULT_CFG;
      acc_q       <= '0;
      out_prod_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (cfg_we) cfg_reg_q <= cfg_wdata;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            snap_q     <= cfg_reg_q;
            acc_q      <= '0;
            state_q    <= accept_nxt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (accept_nxt == DONE) begin
              out_valid_q <= 1'b1;
              out_prod_q  <= '0;
            end
          end
        end
        Q_LL, Q_LH, Q_HL, Q_HH: begin
          acc_q   <= acc_d;
          state_q <= quad_nxt;
          if (quad_nxt == DONE) begin
            out_valid_q <= 1'b1;
            out_prod_q  <= acc_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign busy      = busy_q;
  assign cfg_q     = cfg_reg_q;

endmodule

// File: tb/tb_ncca_seq_mul8_ctrl.sv
// Bench for ncca_seq_mul8_ctrl: arithmetic reference model compared every cycle plus directed literal checks.
module tb_ncca_seq_mul8_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_wdata = '0;
  logic [3:0]  cfg_q;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_prod;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int hs     = 0;

  ncca_seq_mul8_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .cfg_q     (cfg_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: sum of the four nibble products at their place values, LSB pair dropped when approximate.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cfg);
    int sum = 0;
    int an, bn, p;
    for (int q = 0; q < 4; q++) begin
      an = (q >= 2) ? int'(a[7:4]) : int'(a[3:0]);
      bn = (q == 1 || q == 3) ? int'(b[7:4]) : int'(b[3:0]);
      p  = an * bn;
      if (cfg[q]) p = p & ~3;
      sum += p * ((q == 0) ? 1 : (q == 3) ? 256 : 16);
    end
    return sum[15:0];
  endfunction

  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef NCCA_ZERO_SKIP_EN
    int n = 1;
    if (a == 0 || b == 0) return 1;
    for (int q = 0; q < 4; q++) begin
      if (((q >= 2) ? a[7:4] : a[3:0]) != 0 && ((q == 1 || q == 3) ? b[7:4] : b[3:0]) != 0) n++;
    end
    return n;
`else
    return 5;
`endif
  endfunction

  // Transaction-level model: cycles since accept, expected result, held product, config.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_prod = '0;
  logic [3:0]  m_cfg = 4'b0111;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; m_lat = 0; m_prod = '0; m_cfg = 4'b0111;
    end else begin
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_cnt  = 1;
          m_lat  = ref_lat(in_a, in_b);
          m_pend = ref_prod(in_a, in_b, m_cfg);
          if (m_cnt == m_lat) m_prod = m_pend;
        end
      end else if (m_cnt == m_lat) begin
        if (out_ready) m_busy = 1'b0;
      end else begin
        m_cnt++;
        if (m_cnt == m_lat) m_prod = m_pend;
      end
      if (cfg_we) m_cfg = cfg_wdata;
    end
  end

  always @(posedge clk) if (!rst && out_valid && out_ready) hs++;

  always @(negedge clk) begin
    chk("cmp_out_valid", out_valid, m_busy && (m_cnt == m_lat));
    chk("cmp_in_ready", in_ready, !m_busy);
    chk("cmp_busy", busy, m_busy);
    chk("cmp_cfg_q", cfg_q, m_cfg);
    chk("cmp_out_prod", out_prod, m_prod);
  end

  task automatic set_cfg(input logic [3:0] v);
    @(negedge clk); #1; cfg_we = 1'b1; cfg_wdata = v;
    @(negedge clk); #1; cfg_we = 1'b0;
  endtask

  // Runs one transaction; lat counts cycles from accept to out_valid, lo counts cycles with in_ready low.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold, input int wr_cyc,
                         input logic [3:0] wr_val, output logic [15:0] prod, output int lat, output int lo);
    int guard = 0;
    prod = '0; lat = 0; lo = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) chk("accept_wait", in_ready, 1);
    #1; in_a = a; in_b = b; in_valid = 1'b1;
    if (wr_cyc == 0) begin cfg_we = 1'b1; cfg_wdata = wr_val; end
    @(posedge clk); #1; in_valid = 1'b0; cfg_we = 1'b0;
    while (lat < 30) begin
      @(negedge clk); lat++;
      if (!in_ready) lo++;
      if (lat == wr_cyc) begin #1; cfg_we = 1'b1; cfg_wdata = wr_val; end
      else if (cfg_we) begin #1; cfg_we = 1'b0; end
      if (out_valid) break;
    end
    if (!out_valid) chk("done_timeout", out_valid, 1);
    prod = out_prod;
    repeat (hold) @(negedge clk);
    if (hold > 0) begin #1; out_ready = 1'b1; end
    @(posedge clk); #1; cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    int lat, lo, hs0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_prod", out_prod, 16'h0000);
    chk("rst_cfg_q", cfg_q, 4'b0111);
    #1; rst = 1'b0;

    set_cfg(4'b0000);
    run_txn(8'hFF, 8'hFF, 0, -1, 4'h0, p, lat, lo);
    chk("ff_prod", p, 16'hFE01);
    chk("ff_latency", lat, 5);
    chk("ff_in_ready_low", lo, 5);

    set_cfg(4'b1111);
    run_txn(8'h37, 8'h25, 0, -1, 4'h0, p, lat, lo);
    chk("approx_prod", p, 16'h05A0);
    set_cfg(4'b0000);
    run_txn(8'h37, 8'h25, 0, -1, 4'h0, p, lat, lo);
    chk("exact_prod", p, 16'h07F3);

    out_ready = 1'b0;
    hs0 = hs;
    run_txn(8'h12, 8'h34, 7, -1, 4'h0, p, lat, lo);
    chk("bp_prod", p, 16'h03A8);
    chk("bp_in_ready_low", lo, 5);
    repeat (2) @(negedge clk);
    chk("bp_handshakes", hs - hs0, 1);
    chk("bp_prod_after", out_prod, 16'h03A8);

    run_txn(8'h37, 8'h25, 0, 2, 4'b1111, p, lat, lo);
    chk("midwr_prod", p, 16'h07F3);
    chk("midwr_cfg_q", cfg_q, 4'hF);
    run_txn(8'h37, 8'h25, 0, -1, 4'h0, p, lat, lo);
    chk("midwr_next_prod", p, 16'h05A0);

    set_cfg(4'b0000);
    run_txn(8'h37, 8'h25, 0, 0, 4'b1111, p, lat, lo);
    chk("samecyc_prod", p, 16'h07F3);
    chk("samecyc_cfg_q", cfg_q, 4'hF);

    set_cfg(4'b0000);
    @(negedge clk);
    chk("rstmid_ready", in_ready, 1);
    #1; in_a = 8'h37; in_b = 8'h25; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cfg_q", cfg_q, 4'b0111);
    #1; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rstmid_no_stale_valid", out_valid, 0);
    end

    set_cfg(4'b0000);
    run_txn(8'h0F, 8'h0F, 0, -1, 4'h0, p, lat, lo);
    chk("zs_0f_prod", p, 16'h00E1);
`ifdef NCCA_ZERO_SKIP_EN
    chk("zs_0f_latency", lat, 2);
`else
    chk("zs_0f_latency", lat, 5);
`endif
    run_txn(8'h00, 8'h5A, 0, -1, 4'h0, p, lat, lo);
    chk("zs_00_prod", p, 16'h0000);
`ifdef NCCA_ZERO_SKIP_EN
    chk("zs_00_latency", lat, 1);
`else
    chk("zs_00_latency", lat, 5);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
